// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the Hack ALU interface.
// Accepts Hack instructions over a valid/ready handshake and holds the
// architectural A and D registers. A-instructions load A directly. C-instructions
// spend one ISSUE cycle driving the external combinational ALU, then commit the
// dest writes (A/D/M) and the jump decision. The result is then held in RESP until
// the consumer takes it.
// Optional feature macro: ALU_OP_CHECK_EN. When it is defined, an illegal comp code
// raises rsp_err and suppresses all writes and the jump.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ins_valid/ins_ready/ins_data    instruction handshake
//   m_in                            data memory word at m_addr
//   alu_x/alu_y/alu_opr             ALU operands and control {zx,nx,zy,ny,f,no}
//   alu_out/alu_zr/alu_ng           ALU result and flags
//   m_we/m_addr/m_wdata             data memory write port (m_addr also addresses m_in)
//   rsp_valid/rsp_ready             response handshake
//   rsp_result/rsp_jump/rsp_err     response payload
//   a_reg/d_reg                     architectural registers
module alu_issue_ctrl #(
    parameter int unsigned ADDR_W  = 15,
    parameter logic [15:0] RESET_A = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [15:0]       ins_data,
    input  logic [15:0]       m_in,
    output logic [15:0]       alu_x,
    output logic [15:0]       alu_y,
    output logic [5:0]        alu_opr,
    input  logic [15:0]       alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [15:0]       m_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_result,
    output logic              rsp_jump,
    output logic              rsp_err,
    output logic [15:0]       a_reg,
    output logic [15:0]       d_reg
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [6:0]        ctl_q, ctl_d;         // {a, dest[2:0] = A,D,M, jump[2:0]}
    logic [15:0]       y_hold_q, y_hold_d;
    logic [15:0]       a_d, d_d, x_d, res_d, wdata_d;
    logic [5:0]        opr_d;
    logic              jump_d, err_d, we_d, rdy_d, vld_d;
    logic [ADDR_W-1:0] maddr_d;
    logic              hs_c, comp_ok_c, jump_c;
    logic [15:0]       alu_y_c;
    logic              unused_ins_c;

    // Bits [14:13] of a C-instruction carry no meaning.
    assign unused_ins_c = ^ins_data[14:13];

    assign hs_c    = ins_valid & ins_ready;
    assign alu_y_c = ctl_q[6] ? m_in : a_reg;
    assign alu_y   = (state_q == ISSUE) ? alu_y_c : y_hold_q;

`ifdef ALU_OP_CHECK_EN
    // 28 legal encodings: the A/M-based set for either a-bit, and constant/D-only codes for a=0 only.
    function automatic logic comp_legal(input logic a, input logic [5:0] c);
        logic ok;
        ok = 1'b0;
        case (c)
            6'b110000, 6'b110001, 6'b110011, 6'b110111, 6'b110010,
            6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101: ok = 1'b1;
            6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b001101,
            6'b001111, 6'b011111, 6'b001110:                         ok = ~a;
            default:                                                 ok = 1'b0;
        endcase
        return ok;
    endfunction
    assign comp_ok_c = comp_legal(ctl_q[6], alu_opr);
`else
    assign comp_ok_c = 1'b1;
`endif

    assign jump_c = (ctl_q[2] & alu_ng) | (ctl_q[1] & alu_zr) | (ctl_q[0] & ~alu_ng & ~alu_zr);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ctl_q      <= '0;
            y_hold_q   <= '0;
            a_reg      <= RESET_A;
            d_reg      <= '0;
            alu_opr    <= '0;
            alu_x      <= '0;
            rsp_result <= '0;
            rsp_jump   <= 1'b0;
            rsp_err    <= 1'b0;
            m_we       <= 1'b0;
            m_wdata    <= '0;
            m_addr     <= '0;
            ins_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctl_q      <= ctl_d;
            y_hold_q   <= y_hold_d;
            a_reg      <= a_d;
            d_reg      <= d_d;
            alu_opr    <= opr_d;
            alu_x      <= x_d;
            rsp_result <= res_d;
            rsp_jump   <= jump_d;
            rsp_err    <= err_d;
            m_we       <= we_d;
            m_wdata    <= wdata_d;
            m_addr     <= maddr_d;
            ins_ready  <= rdy_d;
            rsp_valid  <= vld_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs_c) state_d = ins_data[15] ? ISSUE : RESP;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the architectural registers.
    always_comb begin
        a_d      = a_reg;
        d_d      = d_reg;
        ctl_d    = ctl_q;
        opr_d    = alu_opr;
        x_d      = alu_x;
        y_hold_d = y_hold_q;
        res_d    = rsp_result;
        jump_d   = rsp_jump;
        err_d    = rsp_err;
        we_d     = 1'b0;
        wdata_d  = m_wdata;
        case (state_q)
            IDLE: begin
                if (hs_c) begin
                    if (!ins_data[15]) begin
                        a_d    = ins_data;
                        res_d  = ins_data;
                        jump_d = 1'b0;
                        err_d  = 1'b0;
                    end else begin
                        ctl_d = {ins_data[12], ins_data[5:0]};
                        opr_d = ins_data[11:6];
                        x_d   = d_reg;
                    end
                end
            end
            ISSUE: begin
                y_hold_d = alu_y_c;
                res_d    = alu_out;
                wdata_d  = alu_out;
                err_d    = ~comp_ok_c;
                jump_d   = comp_ok_c & jump_c;
                we_d     = comp_ok_c & ctl_q[3];
                if (comp_ok_c && ctl_q[4]) d_d = alu_out;
                if (comp_ok_c && ctl_q[5]) a_d = alu_out;
            end
            default: ;
        endcase
        // A write with A and M both as destinations must target the old A.
        maddr_d = (state_q == ISSUE) ? a_reg[ADDR_W-1:0] : a_d[ADDR_W-1:0];
        rdy_d   = (state_d == IDLE);
        vld_d   = (state_d == RESP);
    end

endmodule
